// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Define SIGNED_INPUT_EN to treat bin as two's complement and add the neg output.
module seq_bin2bcd #(
   parameter int IN_WIDTH = 8,
   parameter int DIGITS   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [IN_WIDTH-1:0]   bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
`ifdef SIGNED_INPUT_EN
   ,
   output logic                  neg
`endif
);

   localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int SW = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t              state;
   logic [IN_WIDTH-1:0] shreg;
   logic [SW-1:0]       scratch;
   logic                sticky;
   logic [CW-1:0]       cnt;
`ifdef SIGNED_INPUT_EN
   logic                neg_lat;
`endif

   logic [IN_WIDTH-1:0] mag;
   logic [SW-1:0]       adj;
   logic [SW-1:0]       scratch_nxt;
   logic                carry_out;

   // Per-digit correction; no carry propagates between digits.
   function automatic logic [SW-1:0] add3_digits(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      r = s;
      for (int k = 0; k < DIGITS; k++) begin
         if (s[4*k +: 4] >= 4'd5)
            r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

`ifdef SIGNED_INPUT_EN
   // Magnitude fits in IN_WIDTH unsigned bits, so the most-negative value is exact.
   always_comb begin
      mag = bin;
      if (bin[IN_WIDTH-1])
         mag = (~bin) + IN_WIDTH'(1);
   end
`else
   assign mag = bin;
`endif

   assign adj         = add3_digits(scratch);
   assign scratch_nxt = {adj[SW-2:0], shreg[IN_WIDTH-1]};
   assign carry_out   = adj[SW-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         shreg    <= '0;
         scratch  <= '0;
         sticky   <= 1'b0;
         cnt      <= '0;
`ifdef SIGNED_INPUT_EN
         neg      <= 1'b0;
         neg_lat  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shreg   <= mag;
                  scratch <= '0;
                  sticky  <= 1'b0;
                  cnt     <= CW'(IN_WIDTH - 1);
                  busy    <= 1'b1;
                  state   <= S_SHIFT;
`ifdef SIGNED_INPUT_EN
                  neg_lat <= bin[IN_WIDTH-1];
`endif
               end
            end
            S_SHIFT: begin
               scratch <= scratch_nxt;
               shreg   <= {shreg[IN_WIDTH-2:0], 1'b0};
               sticky  <= sticky | carry_out;
               cnt     <= cnt - CW'(1);
               // Last bit: publish the freshly shifted scratch, not the stale one.
               if (cnt == '0) begin
                  bcd      <= scratch_nxt;
                  overflow <= sticky | carry_out;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_DONE;
`ifdef SIGNED_INPUT_EN
                  neg      <= neg_lat;
`endif
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Self-checking bench for seq_bin2bcd: three parameterisations against an arithmetic model.
module tb_seq_bin2bcd;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_a [3];
   logic [63:0] bin_a   [3];

   logic        b8_busy, b8_done, b8_ovf;
   logic [15:0] b8_bcd;
   logic        b2_busy, b2_done, b2_ovf;
   logic [7:0]  b2_bcd;
   logic        b16_busy, b16_done, b16_ovf;
   logic [19:0] b16_bcd;
`ifdef SIGNED_INPUT_EN
   logic        b8_neg, b2_neg, b16_neg;
   logic        neg_a [3];
   assign neg_a[0] = b8_neg;
   assign neg_a[1] = b2_neg;
   assign neg_a[2] = b16_neg;
`endif

   logic        busy_a [3];
   logic        done_a [3];
   logic        ovf_a  [3];
   logic [63:0] bcd_a  [3];

   assign busy_a[0] = b8_busy;   assign busy_a[1] = b2_busy;   assign busy_a[2] = b16_busy;
   assign done_a[0] = b8_done;   assign done_a[1] = b2_done;   assign done_a[2] = b16_done;
   assign ovf_a[0]  = b8_ovf;    assign ovf_a[1]  = b2_ovf;    assign ovf_a[2]  = b16_ovf;
   assign bcd_a[0]  = 64'(b8_bcd);
   assign bcd_a[1]  = 64'(b2_bcd);
   assign bcd_a[2]  = 64'(b16_bcd);

   seq_bin2bcd #(.IN_WIDTH(8), .DIGITS(4)) u_w8d4 (
      .clk(clk), .rst_n(rst_n), .start(start_a[0]), .bin(bin_a[0][7:0]),
      .busy(b8_busy), .done(b8_done), .bcd(b8_bcd), .overflow(b8_ovf)
`ifdef SIGNED_INPUT_EN
      , .neg(b8_neg)
`endif
   );

   seq_bin2bcd #(.IN_WIDTH(8), .DIGITS(2)) u_w8d2 (
      .clk(clk), .rst_n(rst_n), .start(start_a[1]), .bin(bin_a[1][7:0]),
      .busy(b2_busy), .done(b2_done), .bcd(b2_bcd), .overflow(b2_ovf)
`ifdef SIGNED_INPUT_EN
      , .neg(b2_neg)
`endif
   );

   seq_bin2bcd #(.IN_WIDTH(16), .DIGITS(5)) u_w16d5 (
      .clk(clk), .rst_n(rst_n), .start(start_a[2]), .bin(bin_a[2][15:0]),
      .busy(b16_busy), .done(b16_done), .bcd(b16_bcd), .overflow(b16_ovf)
`ifdef SIGNED_INPUT_EN
      , .neg(b16_neg)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int w_of(input int id);
      return (id == 2) ? 16 : 8;
   endfunction

   function automatic int d_of(input int id);
      case (id)
         0:       return 4;
         1:       return 2;
         default: return 5;
      endcase
   endfunction

   function automatic longint unsigned pow10(input int d);
      longint unsigned p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

   // Decimal value of the input as the converter should interpret it.
   function automatic longint unsigned mag_of(input int id, input logic [63:0] v);
      longint unsigned x;
      int w;
      w = w_of(id);
      x = longint'(v & ((64'd1 << w) - 64'd1));
`ifdef SIGNED_INPUT_EN
      if (((x >> (w - 1)) & 1) == 1) x = (longint'(1) << w) - x;
`endif
      return x;
   endfunction

   function automatic logic [63:0] to_bcd(input longint unsigned v, input int d);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < d; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic check_result(input int id, input logic [63:0] v, input string tag);
      longint unsigned m, p;
      m = mag_of(id, v);
      p = pow10(d_of(id));
      check($sformatf("%s_bcd", tag), bcd_a[id], to_bcd(m % p, d_of(id)));
      check($sformatf("%s_ovf", tag), 64'(ovf_a[id]), 64'(m >= p));
`ifdef SIGNED_INPUT_EN
      check($sformatf("%s_neg", tag), 64'(neg_a[id]), (v >> (w_of(id) - 1)) & 64'd1);
`endif
   endtask

   // One pulsed conversion with latency, busy, output-hold and pulse-width checks.
   task automatic convert(input int id, input logic [63:0] v);
      int          edges, busy_n, w;
      logic        stable;
      logic [63:0] prev_bcd;
      logic        prev_ovf;
      string       tag;
      w   = w_of(id);
      tag = $sformatf("u%0d_%0h", id, v & ((64'd1 << w) - 64'd1));
      @(negedge clk);
      prev_bcd   = bcd_a[id];
      prev_ovf   = ovf_a[id];
      start_a[id] = 1'b1;
      bin_a[id]   = v;
      @(posedge clk);
      #1;
      start_a[id] = 1'b0;
      bin_a[id]   = {$urandom, $urandom};
      edges  = 0;
      busy_n = 0;
      stable = 1'b1;
      while (edges <= 4 * w) begin
         @(negedge clk);
         if (done_a[id]) break;
         if (busy_a[id]) busy_n++;
         if (bcd_a[id] !== prev_bcd || ovf_a[id] !== prev_ovf) stable = 1'b0;
         @(posedge clk);
         edges++;
      end
      check({tag, "_latency"}, 64'(edges), 64'(w));
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(w));
      check({tag, "_held_during_conv"}, 64'(stable), 64'd1);
      check({tag, "_busy_at_done"}, 64'(busy_a[id]), 64'd0);
      check_result(id, v, tag);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(done_a[id]), 64'd0);
   endtask

   task automatic wait_done(input int id, output int at_cyc);
      int n = 0;
      at_cyc = -1;
      while (n < 60) begin
         @(negedge clk);
         n++;
         if (done_a[id]) begin
            at_cyc = cyc;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0, t1, dn;
      logic [63:0] got;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_a[i] = 1'b0;
         bin_a[i]   = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_busy_u%0d", i), 64'(busy_a[i]), 64'd0);
         check($sformatf("rst_done_u%0d", i), 64'(done_a[i]), 64'd0);
         check($sformatf("rst_bcd_u%0d", i), bcd_a[i], 64'd0);
         check($sformatf("rst_ovf_u%0d", i), 64'(ovf_a[i]), 64'd0);
      end
      rst_n = 1'b1;

      convert(0, 64'd255);

      // Back-to-back with start held high.
      @(negedge clk);
      start_a[0] = 1'b1;
      bin_a[0]   = 64'd0;
      wait_done(0, t0);
      check_result(0, 64'd0, "b2b_first");
      bin_a[0] = 64'd99;
      wait_done(0, t1);
      check_result(0, 64'd99, "b2b_second");
      check("b2b_spacing", 64'(t1 - t0), 64'd10);
      check("b2b_both_seen", 64'((t0 >= 0) && (t1 >= 0)), 64'd1);
      start_a[0] = 1'b0;
      repeat (3) @(negedge clk);

      convert(1, 64'd255);
      convert(1, 64'd42);

      // Start while busy is ignored.
      @(negedge clk);
      start_a[0] = 1'b1;
      bin_a[0]   = 64'd200;
      @(posedge clk);
      #1;
      start_a[0] = 1'b0;
      repeat (3) @(negedge clk);
      start_a[0] = 1'b1;
      bin_a[0]   = 64'd7;
      @(negedge clk);
      start_a[0] = 1'b0;
      dn  = 0;
      got = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_a[0]) begin
            dn++;
            got = bcd_a[0];
         end
      end
      check("busy_ignore_dones", 64'(dn), 64'd1);
      check("busy_ignore_bcd", got, to_bcd(200, 4));

      // Reset in the middle of a conversion.
      @(negedge clk);
      start_a[0] = 1'b1;
      bin_a[0]   = 64'd77;
      @(posedge clk);
      #1;
      start_a[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy_a[0]), 64'd0);
      check("midrst_done", 64'(done_a[0]), 64'd0);
      check("midrst_bcd", bcd_a[0], 64'd0);
      check("midrst_ovf", 64'(ovf_a[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done_a[0]) dn++;
      end
      check("midrst_no_done", 64'(dn), 64'd0);
      convert(0, 64'd13);

      convert(2, 64'hFFFF);
      convert(0, 64'h80);
      convert(1, 64'd99);
      convert(1, 64'd100);

      for (int i = 0; i < 10; i++) begin
         for (int id = 0; id < 3; id++) convert(id, 64'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_bin2bcd.md
Name: seq_bin2bcd

Overview:
Parametrised, clocked binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, processing one input bit per clock cycle.
- Replaces unrolled combinational conversion where width makes the logic too deep.
- Feeds the seven-segment/display path of the RISC-V simulator, e.g. register, PC or cycle-count readout.
- Uses a start/busy/done handshake and adds overflow detection.

Parameters:
- IN_WIDTH, 8, binary input width in bits (≥2).
- DIGITS, 4, number of BCD output digits (≥1). Output is exact when 10^DIGITS > 2^IN_WIDTH − 1; otherwise the overflow rule applies.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  IN_WIDTH  unsigned binary value; sampled on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/overflow are updated.
- bcd  output  4*DIGITS  packed BCD result; digit k is bcd[4k+3:4k], digit 0 = ones.
- overflow  output  1  result exceeded DIGITS decimal digits; bcd holds value mod 10^DIGITS.
- neg  output  1  sign of result; exists only with SIGNED_INPUT_EN (see below).

Behaviour:
- Reset (rst_n low, asynchronous, immediate): state=IDLE, busy=0, done=0, bcd=0, overflow=0, neg=0, internal shift/scratch registers=0, bit counter=0.
- Reset mid-conversion aborts it; no done pulse. The first conversion after reset release needs a fresh start.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: latch bin into the input shift register, clear the BCD scratch register and sticky overflow, counter=IN_WIDTH−1, go to SHIFT. busy=1 from E0.
  - start=0: stay in IDLE. Outputs hold the last result.
- SHIFT, each edge:
  - Every scratch digit ≥5 gets +3 (4-bit add, no carry between digits).
  - Then shift {scratch, input_shreg} left by 1; scratch LSB takes the input MSB.
  - The bit shifted out of the top digit's MSB ORs into sticky overflow.
  - Counter decrements. On the edge where counter=0 (edge E_IN_WIDTH): copy scratch→bcd and sticky→overflow, go to DONE.
- DONE (one cycle): done=1, busy=0. Next edge goes to IDLE and done returns to 0.
- Latency: done is high in the cycle after edge E_IN_WIDTH, i.e. the IN_WIDTH-th edge after the accepting edge. Throughput is one conversion per IN_WIDTH+2 cycles when start is held high.
- start while busy or in DONE: ignored, never queued; bin changes are ignored.
- bcd/overflow change only on the completing edge. They are stable at all other times, including during the next conversion.
- Digit arithmetic is 4-bit per digit. Scratch digits are never >9 before the add-3 step.

Optional Feature:
- Macro SIGNED_INPUT_EN.
- Defined:
  - bin is two's complement.
  - At acceptance, neg latches bin[IN_WIDTH−1] and the shift register loads |bin| as an IN_WIDTH-bit unsigned magnitude, so the most-negative value converts correctly (e.g. −128→128).
  - neg updates together with bcd.
  - Zero gives neg=0.
- Undefined: bin is unsigned, and the neg port and its logic are absent.

Test Plan:
- Defaults, bin=8'd255, start pulse → done exactly 8 cycles after the accepting edge; bcd=16'h0255, overflow=0, busy high for those 8 cycles.
- bin=0, then bin=8'd99 back-to-back with start held high → bcd=16'h0000, then 16'h0099. Two done pulses, 10 cycles apart.
- DIGITS=2, bin=8'd255 → bcd=8'h55, overflow=1; following bin=8'd42 → bcd=8'h42, overflow=0.
- start with bin=200, then start with bin=7 three cycles later (busy) → only one done; bcd=16'h0200; bin=7 is never converted.
- Assert rst_n low at cycle 4 of a conversion → busy, done, bcd and overflow go to 0 immediately; no done follows; the next start with bin=13 gives 16'h0013.
- IN_WIDTH=16, DIGITS=5, bin=16'hFFFF → bcd=20'h65535 after 16 cycles. With SIGNED_INPUT_EN, IN_WIDTH=8, bin=8'h80 → neg=1, bcd=16'h0128.
